// File: rtl/sprite_scanline_engine.sv
// Per-scanline sprite evaluator and compositor. The attribute table is scanned into the back
// bank during hblank, and pixels are composited from the front bank during active video.
module sprite_scanline_engine #(
    parameter int MAX_SPRITES = 8,
    parameter int NUM_ATTRS   = 64,
    parameter int SPRITE_W    = 16,
    parameter int SPRITE_H    = 16,
    parameter int PAL_BITS    = 3,
    localparam int ATTR_AW    = $clog2(NUM_ATTRS),
    localparam int ROW_AW     = 8 + $clog2(SPRITE_H),
    localparam int CNT_W      = $clog2(MAX_SPRITES + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_line_start,
    input  logic [9:0]              i_line_y,
    output logic [ATTR_AW-1:0]      o_attr_addr,
    input  logic [31:0]             i_attr_data,
    output logic [ROW_AW-1:0]       o_row_addr,
    input  logic [2*SPRITE_W-1:0]   i_row_data,
    input  logic                    i_pix_valid,
    input  logic [9:0]              i_pix_x,
    output logic [PAL_BITS+1:0]     o_pix_color,
    output logic                    o_pix_opaque,
    output logic                    o_eval_busy,
    output logic [CNT_W-1:0]        o_sprite_count,
    output logic                    o_overflow
);
    localparam int SLOT_W = $clog2(MAX_SPRITES);
    localparam int COL_W  = $clog2(SPRITE_W);
    localparam int HY_W   = $clog2(SPRITE_H);

    typedef enum logic [2:0] {IDLE, A_REQ, A_CHK, R_REQ, R_LOAD, DONE} state_t;

    state_t                  r_state;
    logic                    r_bank_sel;
    logic [MAX_SPRITES-1:0]  r_valid [2];
    logic [2*SPRITE_W-1:0]   r_row   [2][MAX_SPRITES];
    logic [9:0]              r_x     [2][MAX_SPRITES];
    logic [PAL_BITS-1:0]     r_pal   [2][MAX_SPRITES];
    logic                    r_flip  [2][MAX_SPRITES];
    logic [9:0]              r_line_y;
    logic [ATTR_AW-1:0]      r_attr_addr;
    logic [ROW_AW-1:0]       r_row_addr;
    logic [CNT_W-1:0]        r_count;
    logic                    r_overflow;
    logic                    r_busy;
    logic [9:0]              r_cur_x;
    logic [PAL_BITS-1:0]     r_cur_pal;
    logic                    r_cur_flip;
    logic [PAL_BITS+1:0]     r_pix_color;
    logic                    r_pix_opaque;

    logic [9:0]              w_dy;
    logic                    w_hit;
    logic                    w_last;
    logic                    w_back;
    logic [SLOT_W-1:0]       w_slot;
    logic                    w_win;
    logic [PAL_BITS+1:0]     w_color;

    // Unsigned 10-bit distance makes sprites starting below line_y wrap to large values and miss.
    assign w_dy   = r_line_y - i_attr_data[9:0];
    assign w_hit  = (w_dy < 10'(SPRITE_H));
    assign w_last = (r_attr_addr == ATTR_AW'(NUM_ATTRS - 1));
    assign w_back = ~r_bank_sel;
    assign w_slot = r_count[SLOT_W-1:0];

    // Evaluation FSM: bank swap, attribute scan, and slot bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_bank_sel  <= 1'b0;
            r_valid[0]  <= '0;
            r_valid[1]  <= '0;
            r_line_y    <= 10'd0;
            r_attr_addr <= '0;
            r_row_addr  <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_busy      <= 1'b0;
            r_cur_x     <= 10'd0;
            r_cur_pal   <= '0;
            r_cur_flip  <= 1'b0;
        end else if (i_line_start) begin
            r_bank_sel          <= ~r_bank_sel;
            r_valid[r_bank_sel] <= '0;
            r_line_y            <= i_line_y;
            r_attr_addr         <= '0;
            r_count             <= '0;
            r_overflow          <= 1'b0;
            r_busy              <= 1'b1;
            r_state             <= A_REQ;
        end else begin
            case (r_state)
                IDLE: r_state <= IDLE;
                A_REQ: r_state <= A_CHK;
                A_CHK: begin
                    if (w_hit) begin
                        if (r_count == CNT_W'(MAX_SPRITES)) begin
                            r_overflow <= 1'b1;
                            r_busy     <= 1'b0;
                            r_state    <= DONE;
                        end else begin
                            r_row_addr <= {i_attr_data[27:20], w_dy[HY_W-1:0]};
                            r_cur_x    <= i_attr_data[19:10];
                            r_cur_pal  <= i_attr_data[28 +: PAL_BITS];
                            r_cur_flip <= i_attr_data[31];
                            r_state    <= R_REQ;
                        end
                    end else if (w_last) begin
                        r_busy  <= 1'b0;
                        r_state <= DONE;
                    end else begin
                        r_attr_addr <= r_attr_addr + ATTR_AW'(1);
                        r_state     <= A_REQ;
                    end
                end
                R_REQ: r_state <= R_LOAD;
                R_LOAD: begin
                    r_valid[w_back][w_slot] <= 1'b1;
                    r_count                 <= r_count + CNT_W'(1);
                    if (w_last) begin
                        r_busy  <= 1'b0;
                        r_state <= DONE;
                    end else begin
                        r_attr_addr <= r_attr_addr + ATTR_AW'(1);
                        r_state     <= A_REQ;
                    end
                end
                DONE: r_state <= IDLE;
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Slot payload storage; validity bits alone decide whether a slot is live.
    always_ff @(posedge clk) begin
        if (!i_line_start && r_state == R_LOAD) begin
            r_row[w_back][w_slot]  <= i_row_data;
            r_x[w_back][w_slot]    <= r_cur_x;
            r_pal[w_back][w_slot]  <= r_cur_pal;
            r_flip[w_back][w_slot] <= r_cur_flip;
        end
    end

    // Compositor: walk slots from highest to lowest index so the lowest opaque one wins.
    always_comb begin
        logic [9:0]       dx;
        logic [COL_W-1:0] col;
        logic [1:0]       px;
        logic             take;
        w_win   = 1'b0;
        w_color = '0;
        dx      = 10'd0;
        col     = '0;
        px      = 2'b00;
        take    = 1'b0;
        for (int s = MAX_SPRITES - 1; s >= 0; s--) begin
            dx      = i_pix_x - r_x[r_bank_sel][s];
            col     = r_flip[r_bank_sel][s] ? (COL_W'(SPRITE_W - 1) - dx[COL_W-1:0]) : dx[COL_W-1:0];
            px      = r_row[r_bank_sel][s][{col, 1'b0} +: 2];
            take    = r_valid[r_bank_sel][s] && (dx < 10'(SPRITE_W)) && (px != 2'b00);
            w_color = take ? {r_pal[r_bank_sel][s], px} : w_color;
            w_win   = take | w_win;
        end
    end

    // Pixel output register, held between pix_valid pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pix_color  <= '0;
            r_pix_opaque <= 1'b0;
        end else if (i_pix_valid) begin
            r_pix_color  <= w_color;
            r_pix_opaque <= w_win;
        end
    end

    assign o_attr_addr    = r_attr_addr;
    assign o_row_addr     = r_row_addr;
    assign o_pix_color    = r_pix_color;
    assign o_pix_opaque   = r_pix_opaque;
    assign o_eval_busy    = r_busy;
    assign o_sprite_count = r_count;
    assign o_overflow     = r_overflow;

endmodule
